// File: rtl/relay_pkg.sv
// Shared types and default constants for the relay transmit encoder.
package relay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        GAP,
        PARITY
    } relay_state_t;

    localparam int RELAY_SYMBOL_LEN = 64;
    localparam int RELAY_FIFO_DEPTH = 8;
    localparam int RELAY_GAP_LEN    = 128;

    // Guard-band symbols hold the bit for 3/4 of the symbol, low for the rest.
    localparam int RELAY_GUARD_NUM  = 3;
    localparam int RELAY_GUARD_DEN  = 4;

endpackage

// File: rtl/relay_bit_fifo.sv
// Synchronous FIFO of {bit, last} entries with count and empty flag.
module relay_bit_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  logic [1:0]             i_wr_data,
    input  logic                   i_rd_en,
    output logic [1:0]             o_rd_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int unsigned DEPTH_U = DEPTH;
    localparam logic [AW:0] FULL_CNT = DEPTH_U[AW:0];

    logic [1:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;

    assign w_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_rd      = i_rd_en && !o_empty;
    // A write while full is accepted only when a pop frees the slot in the same cycle.
    assign w_wr      = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/relay_encode.sv
// Relay link transmitter: serialises FIFO bits into oversampled symbols.
// Optional trailing even-parity symbol when RELAY_ENCODE_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line low, waiting for a queued bit
// START  | emitting the '1' start symbol
// DATA   | popping one bit per symbol; '0' symbol and underrun if FIFO empty
// PARITY | emitting even parity of the payload (parity build only)
// GAP    | line forced low for GAP_LEN cycles
module relay_encode
    import relay_pkg::*;
#(
    parameter int SYMBOL_LEN = RELAY_SYMBOL_LEN,
    parameter int FIFO_DEPTH = RELAY_FIFO_DEPTH,
    parameter int GAP_LEN    = RELAY_GAP_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mode,
    input  logic bit_in,
    input  logic bit_last,
    input  logic bit_valid,
    output logic bit_ready,
    output logic data_out,
    output logic busy,
    output logic underrun
);
    localparam int SW = $clog2(SYMBOL_LEN);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(GAP_LEN + 1);
    localparam int unsigned GUARD_U = SYMBOL_LEN * RELAY_GUARD_NUM / RELAY_GUARD_DEN;
    localparam int unsigned DEPTH_U = FIFO_DEPTH;
    localparam int unsigned GAP_U   = GAP_LEN - 1;
    localparam logic [SW-1:0] GUARD_CNT = GUARD_U[SW-1:0];
    localparam logic [SW-1:0] SYM_LAST  = '1;
    localparam logic [CW-1:0] FULL_CNT  = DEPTH_U[CW-1:0];
    localparam logic [GW-1:0] GAP_LOAD  = GAP_U[GW-1:0];

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic          w_wr;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic [1:0]    w_head;
    logic [CW-1:0] w_count;

    relay_state_t  r_state;
    logic [SW-1:0] r_sym_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_mode_q;
    logic          r_bit;
    logic          r_last;
    logic          r_data_out;
    logic          r_underrun;
`ifdef RELAY_ENCODE_PARITY_EN
    logic          r_par;
`endif

    // Reset asserts immediately and releases two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_full    = (w_count == FULL_CNT);
    assign bit_ready = !w_full;
    assign w_wr      = bit_valid && !w_full;
    assign w_pop     = (r_state == DATA) && (r_sym_cnt == '0) && !w_empty;
    assign data_out  = r_data_out;
    assign busy      = (r_state != IDLE);
    assign underrun  = r_underrun;

    relay_bit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (w_rst_n),
        .i_wr_en   (w_wr),
        .i_wr_data ({bit_in, bit_last}),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    function automatic logic f_shape(input logic i_b, input logic i_m, input logic [SW-1:0] i_cnt);
        return i_b && (!i_m || (i_cnt < GUARD_CNT));
    endfunction

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_sym_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_mode_q   <= 1'b0;
            r_bit      <= 1'b0;
            r_last     <= 1'b0;
            r_data_out <= 1'b0;
            r_underrun <= 1'b0;
`ifdef RELAY_ENCODE_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_data_out <= 1'b0;
                    r_sym_cnt  <= '0;
                    if (!w_empty) begin
                        r_mode_q <= mode;
                        r_state  <= START;
`ifdef RELAY_ENCODE_PARITY_EN
                        r_par    <= 1'b0;
`endif
                    end
                end
                START: begin
                    r_data_out <= f_shape(1'b1, r_mode_q, r_sym_cnt);
                    r_sym_cnt  <= r_sym_cnt + 1'b1;
                    if (r_sym_cnt == SYM_LAST) r_state <= DATA;
                end
                DATA: begin
                    if (r_sym_cnt == '0) begin
                        if (!w_empty) begin
                            r_bit      <= w_head[1];
                            r_last     <= w_head[0];
                            r_data_out <= f_shape(w_head[1], r_mode_q, r_sym_cnt);
`ifdef RELAY_ENCODE_PARITY_EN
                            r_par      <= r_par ^ w_head[1];
`endif
                        end else begin
                            r_bit      <= 1'b0;
                            r_last     <= 1'b0;
                            r_data_out <= 1'b0;
                            r_underrun <= 1'b1;
                        end
                    end else begin
                        r_data_out <= f_shape(r_bit, r_mode_q, r_sym_cnt);
                    end
                    r_sym_cnt <= r_sym_cnt + 1'b1;
                    if ((r_sym_cnt == SYM_LAST) && r_last) begin
`ifdef RELAY_ENCODE_PARITY_EN
                        r_bit     <= r_par;
                        r_state   <= PARITY;
`else
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= GAP;
`endif
                    end
                end
`ifdef RELAY_ENCODE_PARITY_EN
                PARITY: begin
                    r_data_out <= f_shape(r_bit, r_mode_q, r_sym_cnt);
                    r_sym_cnt  <= r_sym_cnt + 1'b1;
                    if (r_sym_cnt == SYM_LAST) begin
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= GAP;
                    end
                end
`endif
                GAP: begin
                    r_data_out <= 1'b0;
                    if (r_gap_cnt == '0) r_state <= IDLE;
                    else                 r_gap_cnt <= r_gap_cnt - 1'b1;
                end
                default: begin
                    r_data_out <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule
